// File: rtl/ifq_line_fetch.sv
// ---------------------------------------------------------------------------
// ifq_line_fetch
//
// Purpose:
//   Fetches 128-bit instruction lines (4 x 32-bit words) from instruction
//   memory at sequential 16-byte line addresses, one request outstanding at a
//   time, and writes each line into the instruction fetch queue (IFQ).
//   A redirect (taken branch/jump) discards stale memory traffic and delivers
//   the target line together with the IFQ flush strobe and the word index of
//   the target instruction inside that line.
//
// Handshake rules (strict, no back-pressure on memory):
//   - o_mem_req is a one-cycle pulse; memory answers with exactly one
//     i_mem_valid pulse at least one cycle later.
//   - IFQ write happens in a cycle where o_ifq_wen=1 (only when !i_ifq_full);
//     a flush write (o_ifq_flush=1) is unconditional and ignores i_ifq_full.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_redirect, i_redirect_pc    one-cycle redirect strobe and target address
//   i_ifq_full                   IFQ full flag
//   o_mem_req, o_mem_addr        memory request pulse and line address
//   i_mem_valid, i_mem_data      memory response strobe and line
//   o_ifq_wdata, o_ifq_wen       line to IFQ and its write enable
//   o_ifq_flush                  IFQ flush; o_ifq_wdata is the target line
//   o_ifq_jmp_b_3_2              target word index, valid with o_ifq_flush
//   o_fetch_pc                   current line address (same as o_mem_addr)
//   o_state                      FSM state, for debug/checkers
// ---------------------------------------------------------------------------
module ifq_line_fetch #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h0040_0000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_redirect,
  input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
  input  logic                  i_ifq_full,
  output logic                  o_mem_req,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic                  i_mem_valid,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  output logic [DATA_WIDTH-1:0] o_ifq_wdata,
  output logic                  o_ifq_wen,
  output logic                  o_ifq_flush,
  output logic [1:0]            o_ifq_jmp_b_3_2,
  output logic [ADDR_WIDTH-1:0] o_fetch_pc,
  output logic [2:0]            o_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DROP  = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LINE_STEP = ADDR_WIDTH'(16);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   line_pc;
  logic [1:0]              word_idx;
  logic                    pend_flush;
  logic [DATA_WIDTH-1:0]   line_buf;
  logic [ADDR_WIDTH-1:0]   redirect_line;
  logic [ADDR_WIDTH-1:0]   line_addr;

  // Byte-in-word bits of the target and the in-line offset of line_pc are
  // never needed: fetch works on whole lines, the IFQ gets only the word index.
  logic unused_bits;
  assign unused_bits = ^{i_redirect_pc[1:0], line_pc[3:0]};

  assign redirect_line = {i_redirect_pc[ADDR_WIDTH-1:4], 4'b0000};
  assign line_addr     = {line_pc[ADDR_WIDTH-1:4], 4'b0000};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      line_pc    <= RESET_PC;
      word_idx   <= 2'b00;
      pend_flush <= 1'b0;
      line_buf   <= '0;
    end else if (i_redirect) begin
      // Latest redirect always wins; whatever is in flight becomes stale.
      line_pc    <= redirect_line;
      word_idx   <= i_redirect_pc[3:2];
      pend_flush <= 1'b1;
      case (state)
        // Request already sent (or being sent this cycle): its response
        // must still be absorbed before a new request may go out.
        S_ISSUE: state <= S_DROP;
        S_WAIT:  state <= i_mem_valid ? S_ISSUE : S_DROP;
        S_DROP:  state <= i_mem_valid ? S_ISSUE : S_DROP;
        // IDLE and WRITE have nothing outstanding.
        default: state <= S_ISSUE;
      endcase
    end else begin
      case (state)
        S_IDLE:  state <= S_ISSUE;
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (i_mem_valid) begin
            line_buf <= i_mem_data;
            state    <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (pend_flush) begin
            pend_flush <= 1'b0;
            line_pc    <= line_pc + LINE_STEP;
            state      <= S_ISSUE;
          end else if (!i_ifq_full) begin
            line_pc <= line_pc + LINE_STEP;
            state   <= S_ISSUE;
          end
        end
        S_DROP: begin
          if (i_mem_valid) state <= S_ISSUE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A redirect landing in WRITE kills the buffered line in the same cycle.
  assign o_mem_req       = (state == S_ISSUE);
  assign o_mem_addr      = line_addr;
  assign o_fetch_pc      = line_addr;
  assign o_ifq_wdata     = line_buf;
  assign o_ifq_jmp_b_3_2 = word_idx;
  assign o_ifq_flush     = (state == S_WRITE) && pend_flush && !i_redirect;
  assign o_ifq_wen       = (state == S_WRITE) && !pend_flush && !i_ifq_full
                           && !i_redirect;
  assign o_state         = state;

endmodule

// File: tb/tb_ifq_line_fetch.sv
// ---------------------------------------------------------------------------
// tb_ifq_line_fetch
//
// Directed bench for ifq_line_fetch. Inputs are driven 1 ns after the rising
// edge, outputs are sampled 2 ns later (well before the next rising edge).
// Memory responses are scripted by hand to land exactly where each step needs.
// ---------------------------------------------------------------------------
module tb_ifq_line_fetch;

  logic         i_clk;
  logic         i_rst;
  logic         i_redirect;
  logic [31:0]  i_redirect_pc;
  logic         i_ifq_full;
  logic         o_mem_req;
  logic [31:0]  o_mem_addr;
  logic         i_mem_valid;
  logic [127:0] i_mem_data;
  logic [127:0] o_ifq_wdata;
  logic         o_ifq_wen;
  logic         o_ifq_flush;
  logic [1:0]   o_ifq_jmp_b_3_2;
  logic [31:0]  o_fetch_pc;
  logic [2:0]   o_state;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_DROP  = 3'd4;

  localparam logic [127:0] L0     = 128'h1000_0003_1000_0002_1000_0001_1000_0000;
  localparam logic [127:0] L1     = 128'h1100_0003_1100_0002_1100_0001_1100_0000;
  localparam logic [127:0] L2     = 128'h1200_0003_1200_0002_1200_0001_1200_0000;
  localparam logic [127:0] L3     = 128'h1300_0003_1300_0002_1300_0001_1300_0000;
  localparam logic [127:0] STALE  = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
  localparam logic [127:0] T1     = 128'h2000_0003_2000_0002_2000_0001_2000_0000;
  localparam logic [127:0] STALE2 = 128'hBAD0_BAD1_BAD2_BAD3_BAD4_BAD5_BAD6_BAD7;
  localparam logic [127:0] Z0     = 128'h3000_0003_3000_0002_3000_0001_3000_0000;
  localparam logic [127:0] A1     = 128'h4000_0003_4000_0002_4000_0001_4000_0000;
  localparam logic [127:0] WL     = 128'h5000_0003_5000_0002_5000_0001_5000_0000;
  localparam logic [127:0] R0     = 128'h6000_0003_6000_0002_6000_0001_6000_0000;

  ifq_line_fetch #(
    .DATA_WIDTH(128),
    .ADDR_WIDTH(32),
    .RESET_PC  (32'h0040_0000)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_redirect     (i_redirect),
    .i_redirect_pc  (i_redirect_pc),
    .i_ifq_full     (i_ifq_full),
    .o_mem_req      (o_mem_req),
    .o_mem_addr     (o_mem_addr),
    .i_mem_valid    (i_mem_valid),
    .i_mem_data     (i_mem_data),
    .o_ifq_wdata    (o_ifq_wdata),
    .o_ifq_wen      (o_ifq_wen),
    .o_ifq_flush    (o_ifq_flush),
    .o_ifq_jmp_b_3_2(o_ifq_jmp_b_3_2),
    .o_fetch_pc     (o_fetch_pc),
    .o_state        (o_state)
  );

  // Clock / reset block
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called while in ISSUE (settled); returns settled in WRITE holding data.
  task automatic fetch_line(input string tag, input logic [31:0] addr, input logic [127:0] data);
    chk({tag, "_req"}, o_mem_req, 1'b1);
    chk({tag, "_addr"}, o_mem_addr, addr);
    chk({tag, "_pc"}, o_fetch_pc, addr);
    tick(); settle();
    chk({tag, "_wait_req"}, o_mem_req, 1'b0);
    i_mem_valid = 1'b1;
    i_mem_data  = data;
    tick();
    i_mem_valid = 1'b0;
    i_mem_data  = '0;
    settle();
  endtask

  task automatic chk_write(input string tag, input logic [127:0] data);
    chk({tag, "_wen"}, o_ifq_wen, 1'b1);
    chk({tag, "_flush"}, o_ifq_flush, 1'b0);
    chk({tag, "_wdata"}, o_ifq_wdata, data);
    chk({tag, "_req"}, o_mem_req, 1'b0);
  endtask

  task automatic chk_flush(input string tag, input logic [127:0] data, input logic [1:0] idx);
    chk({tag, "_flush"}, o_ifq_flush, 1'b1);
    chk({tag, "_wen"}, o_ifq_wen, 1'b0);
    chk({tag, "_wdata"}, o_ifq_wdata, data);
    chk({tag, "_idx"}, o_ifq_jmp_b_3_2, idx);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, o_state, ST_IDLE);
    chk({tag, "_req"}, o_mem_req, 1'b0);
    chk({tag, "_wen"}, o_ifq_wen, 1'b0);
    chk({tag, "_flush"}, o_ifq_flush, 1'b0);
    chk({tag, "_idx"}, o_ifq_jmp_b_3_2, 2'b00);
    chk({tag, "_wdata"}, o_ifq_wdata, 128'h0);
    chk({tag, "_addr"}, o_mem_addr, 32'h0040_0000);
    chk({tag, "_pc"}, o_fetch_pc, 32'h0040_0000);
  endtask

  // Directed stimulus with inline scoreboard checks
  initial begin
    i_rst         = 1'b1;
    i_redirect    = 1'b0;
    i_redirect_pc = '0;
    i_ifq_full    = 1'b0;
    i_mem_valid   = 1'b0;
    i_mem_data    = '0;

    // Reset state
    tick(); tick(); settle();
    chk_reset_outputs("rst");
    i_rst = 1'b0;

    // Sequential fetch of L0, L1, L2
    tick(); settle();
    chk("seq_state_issue", o_state, ST_ISSUE);
    fetch_line("l0", 32'h0040_0000, L0);
    chk_write("l0_wr", L0);
    tick(); settle();
    fetch_line("l1", 32'h0040_0010, L1);

    // IFQ full for 5 cycles while holding L1
    i_ifq_full = 1'b1;
    settle();
    for (int i = 0; i < 5; i++) begin
      chk("full_wen", o_ifq_wen, 1'b0);
      chk("full_req", o_mem_req, 1'b0);
      chk("full_addr", o_mem_addr, 32'h0040_0010);
      chk("full_wdata", o_ifq_wdata, L1);
      tick(); settle();
    end
    i_ifq_full = 1'b0;
    settle();
    chk_write("l1_wr", L1);
    tick(); settle();
    chk("l1_once_wen", o_ifq_wen, 1'b0);
    fetch_line("l2", 32'h0040_0020, L2);
    chk_write("l2_wr", L2);
    tick(); settle();

    // Redirect in WAIT, stale response two cycles later
    chk("l3_req", o_mem_req, 1'b1);
    chk("l3_addr", o_mem_addr, 32'h0040_0030);
    tick(); settle();
    chk("rd1_state_wait", o_state, ST_WAIT);
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h0040_1238;
    tick();
    i_redirect = 1'b0;
    settle();
    chk("rd1_state_drop", o_state, ST_DROP);
    chk("rd1_drop_req", o_mem_req, 1'b0);
    chk("rd1_drop_addr", o_mem_addr, 32'h0040_1230);
    tick();
    i_mem_valid = 1'b1;
    i_mem_data  = STALE;
    settle();
    chk("rd1_stale_wen", o_ifq_wen, 1'b0);
    chk("rd1_stale_flush", o_ifq_flush, 1'b0);
    chk("rd1_stale_state", o_state, ST_DROP);
    tick();
    i_mem_valid = 1'b0;
    i_mem_data  = '0;
    settle();
    chk("rd1_after_drop_wen", o_ifq_wen, 1'b0);
    fetch_line("tgt1", 32'h0040_1230, T1);
    chk_flush("tgt1_fl", T1, 2'b10);
    tick(); settle();
    chk("tgt1_next_flush", o_ifq_flush, 1'b0);

    // Redirect coincident with a response in WAIT
    chk("rd2_pre_addr", o_mem_addr, 32'h0040_1240);
    chk("rd2_pre_req", o_mem_req, 1'b1);
    tick(); settle();
    i_mem_valid   = 1'b1;
    i_mem_data    = STALE2;
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h0000_0004;
    tick();
    i_mem_valid = 1'b0;
    i_mem_data  = '0;
    i_redirect  = 1'b0;
    settle();
    chk("rd2_state", o_state, ST_ISSUE);
    chk("rd2_wen", o_ifq_wen, 1'b0);
    fetch_line("tgt2", 32'h0000_0000, Z0);
    chk_flush("tgt2_fl", Z0, 2'b01);
    tick(); settle();

    // Redirect during a normal WRITE kills that write
    fetch_line("a1", 32'h0000_0010, A1);
    i_redirect    = 1'b1;
    i_redirect_pc = 32'hFFFF_FFF0;
    settle();
    chk("rd3_wen", o_ifq_wen, 1'b0);
    chk("rd3_flush", o_ifq_flush, 1'b0);
    tick();
    i_redirect = 1'b0;
    settle();

    // Flush write ignores a full IFQ; line address then wraps to 0
    fetch_line("wrap", 32'hFFFF_FFF0, WL);
    i_ifq_full = 1'b1;
    settle();
    chk_flush("wrap_fl", WL, 2'b00);
    tick();
    i_ifq_full = 1'b0;
    settle();
    chk("wrap_req", o_mem_req, 1'b1);
    chk("wrap_addr", o_mem_addr, 32'h0000_0000);

    // Reset with a request in flight
    tick(); settle();
    chk("rst2_pre_state", o_state, ST_WAIT);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    settle();
    chk_reset_outputs("rst2");
    tick(); settle();
    fetch_line("r0", 32'h0040_0000, R0);
    chk_write("r0_wr", R0);
    tick(); settle();
    chk("r0_next_addr", o_mem_addr, 32'h0040_0010);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // L3 is declared for completeness of the line set but only addresses of
  // its request are exercised (the redirect discards it).
  logic [127:0] unused_l3;
  assign unused_l3 = L3;

endmodule

// File: doc/ifq_line_fetch.md
Name: ifq_line_fetch

Overview:
- Upstream neighbour of the instruction fetch queue (IFQ) in the RISC-V superscalar front end.
- Fetches 128-bit instruction lines (4 × 32-bit) from instruction memory, one request outstanding at a time, at sequential 16-byte line addresses.
- Writes each line into the IFQ, honouring its full flag.
- On a branch/jump redirect, discards stale traffic and delivers the target line together with the IFQ flush strobe and the target word index.

Parameters:
DATA_WIDTH, 128, line width in bits (4 instructions)
ADDR_WIDTH, 32, byte address width
RESET_PC, 32'h0040_0000, first fetch address after reset (must be 16-byte aligned)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset; one clock; reset is synchronous and active-high
i_redirect  in  1  one-cycle redirect (taken branch/jump) strobe
i_redirect_pc  in  ADDR_WIDTH  redirect target byte address
i_ifq_full  in  1  IFQ full flag
o_mem_req  out  1  one-cycle request pulse to instruction memory
o_mem_addr  out  ADDR_WIDTH  line address; bits [3:0] always 0
i_mem_valid  in  1  one-cycle response strobe; exactly one per request, ≥1 cycle after o_mem_req
i_mem_data  in  DATA_WIDTH  response line, valid with i_mem_valid
o_ifq_wdata  out  DATA_WIDTH  line to IFQ
o_ifq_wen  out  1  IFQ write enable
o_ifq_flush  out  1  IFQ flush; o_ifq_wdata is the target line in this cycle
o_ifq_jmp_b_3_2  out  2  target word index (redirect_pc[3:2]), valid with o_ifq_flush
o_fetch_pc  out  ADDR_WIDTH  current line address (= o_mem_addr)

Behaviour:
- State registers: state ∈ {IDLE, ISSUE, WAIT, WRITE, DROP}, line_pc, word_idx[1:0], pend_flush, line_buf.
- Reset (i_rst high at a clock edge, from any state, including with a request in flight):
  - state=IDLE, line_pc=RESET_PC, word_idx=0, pend_flush=0, line_buf=0.
  - All outputs 0 except o_mem_addr/o_fetch_pc = RESET_PC.
  - Reset has priority over every other input.
  - A response arriving after reset for a pre-reset request is a memory-side violation; the bench must not generate one.
- o_mem_req = (state==ISSUE); o_mem_addr = {line_pc[31:4],4'b0}.
- State transitions with no redirect:
  - IDLE → ISSUE.
  - ISSUE → WAIT.
  - WAIT: stays until i_mem_valid. On valid: line_buf ← i_mem_data, go to WRITE.
  - WRITE, pend_flush=1: o_ifq_flush=1, o_ifq_wen=0, ignores i_ifq_full. Then pend_flush←0, line_pc+=16, go to ISSUE.
  - WRITE, pend_flush=0 and !i_ifq_full: o_ifq_wen=1, line_pc+=16, go to ISSUE.
  - WRITE, pend_flush=0 and i_ifq_full: hold; o_ifq_wen=0, line_buf and line_pc unchanged.
- o_ifq_wdata = line_buf in every state. o_ifq_jmp_b_3_2 = word_idx.
- Redirect (i_redirect=1, no reset), in every state:
  - line_pc ← {i_redirect_pc[31:4],4'b0}, word_idx ← i_redirect_pc[3:2], pend_flush ← 1.
  - Next state:
    - ISSUE → DROP (the pulse in this cycle is stale).
    - WAIT without valid → DROP.
    - WAIT with valid → ISSUE (response discarded).
    - WRITE → ISSUE (buffered line discarded; o_ifq_wen and o_ifq_flush forced 0 this cycle).
    - DROP → DROP, or ISSUE if valid in the same cycle.
    - IDLE → ISSUE.
- DROP: o_mem_req=0. On i_mem_valid, discard data and go to ISSUE.
- Back-to-back redirects: the latest target wins; pend_flush stays 1.
- Latency: at least 3 cycles from ISSUE to IFQ write (ISSUE, ≥1 WAIT, WRITE). Steady state, zero-wait memory: one line every 3 cycles.
- Address arithmetic: line_pc wraps modulo 2^ADDR_WIDTH; 32'hFFFF_FFF0 + 16 → 0.
- Throttle: no new request is issued while in WRITE. A full IFQ therefore throttles fetch with no loss and no duplicate lines.

Test Plan:
- Reset, memory responds 1 cycle after each request with lines L0,L1,L2 → o_mem_addr 0x00400000, 0x00400010, 0x00400020; o_ifq_wen once per line in order; o_ifq_flush never 1.
- i_ifq_full=1 for 5 cycles while in WRITE holding L1 → o_ifq_wen=0, no o_mem_req, o_mem_addr stays 0x00400010. Full drops → L1 written once, next request to 0x00400020.
- Redirect to 0x00401238 while in WAIT; stale response arrives 2 cycles later → stale data not written. Next request to 0x00401230. Its line is written with o_ifq_flush=1, o_ifq_jmp_b_3_2=2'b10, o_ifq_wen=0. Following request to 0x00401240.
- Redirect to 0x00000004 coincident with i_mem_valid in WAIT → response discarded, ISSUE next cycle at 0x00000000, flush write carries index 2'b01. Redirect in WRITE with i_ifq_full=0 → no write that cycle.
- Flush pending while i_ifq_full=1 → flush write still occurs. Line_pc at 0xFFFFFFF0 after one write → next o_mem_addr 0x00000000.
- i_rst asserted in WAIT → next cycle IDLE, all outputs 0, o_mem_addr=0x00400000; one cycle later o_mem_req pulses at 0x00400000.
